packet_eval_output_mp: RTL and testbench

PACKET_EVAL_OUTPUT_MP -- requirements
Module: packet_eval_output_mp

---
 rtl/packet_eval_pkg.sv | 32 +++
 rtl/packet_eval_regs.sv | 132 +++++++++++++
 rtl/packet_eval_output_mp.sv | 180 ++++++++++++++++++
 tb/tb_packet_eval_output_mp.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_eval_pkg.sv
// Shared definitions for the packet evaluation block:
// register offsets, tuser field positions and packet FSM states.
package packet_eval_pkg;

  localparam logic [31:0] REG_CTRL     = 32'h00;
  localparam logic [31:0] REG_FWD_CNT  = 32'h04;
  localparam logic [31:0] REG_DROP_CNT = 32'h08;
  localparam logic [31:0] REG_DST_MAP  = 32'h10;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

  localparam int TU_LEN_LSB = 0;
  localparam int TU_SRC_LSB = 16;
  localparam int TU_DST_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP,
    ST_BYPASS
  } pkt_state_e;

  // Index of the lowest set bit; 8 when no bit is set.
  function automatic logic [3:0] lowest_bit(input logic [7:0] v);
    lowest_bit = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_bit = 4'(i);
    end
  endfunction

endpackage

// File: rtl/packet_eval_regs.sv
// AXI-lite register slave: control, per-port destination map
// and saturating forward/drop counters.
module packet_eval_regs
  import packet_eval_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'h7080_0000,
  parameter logic [31:0] C_HIGHADDR         = 32'h7080_ffff,
  parameter int          C_NUM_PORTS        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic                            fwd_inc,
  input  logic                            drop_inc,
  output logic                            enable,
  output logic [63:0]                     dst_flat
);

  logic [7:0]  dst_map [C_NUM_PORTS];
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] wr_off;
  logic [31:0] rd_off;
  logic        wr_in;
  logic        rd_in;
  logic        wr_take;
  logic        wr_hs;
  logic        rd_hs;
  logic        wr_en;
  logic        clr;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
  logic        unused_ok;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= C_BASEADDR) && (a <= C_HIGHADDR);
  endfunction

  assign wr_off  = 32'(s_axi_awaddr) - C_BASEADDR;
  assign rd_off  = 32'(s_axi_araddr) - C_BASEADDR;
  assign wr_in   = in_range(32'(s_axi_awaddr));
  assign rd_in   = in_range(32'(s_axi_araddr));
  assign wr_take = !s_axi_awready && !s_axi_bvalid
                && s_axi_awvalid && s_axi_wvalid;
  assign wr_hs   = s_axi_awvalid && s_axi_awready
                && s_axi_wvalid && s_axi_wready;
  assign rd_hs   = s_axi_arvalid && s_axi_arready;
  assign wr_en   = wr_hs && wr_in && s_axi_wstrb[0];
  assign clr     = wr_en && (wr_off == REG_CTRL)
                && s_axi_wdata[CTRL_CLEAR];

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign unused_ok   = ^{s_axi_wdata, s_axi_wstrb};

  always_comb begin
    rd_data = '0;
    if (rd_in) begin
      if (rd_off == REG_CTRL) rd_data[0] = enable;
      if (rd_off == REG_FWD_CNT) rd_data[31:0] = fwd_cnt;
      if (rd_off == REG_DROP_CNT) rd_data[31:0] = drop_cnt;
      for (int i = 0; i < C_NUM_PORTS; i++) begin
        if (rd_off == REG_DST_MAP + 32'(4 * i))
          rd_data[7:0] = dst_map[i];
      end
    end
  end

  always_comb begin
    dst_flat = '0;
    for (int i = 0; i < C_NUM_PORTS; i++)
      dst_flat[i*8 +: 8] = dst_map[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      enable        <= 1'b0;
      fwd_cnt       <= '0;
      drop_cnt      <= '0;
      for (int i = 0; i < C_NUM_PORTS; i++) dst_map[i] <= '0;
    end else begin
      s_axi_awready <= wr_take;
      s_axi_wready  <= wr_take;
      if (wr_hs) s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      s_axi_arready <= !s_axi_arready && !s_axi_rvalid
                    && s_axi_arvalid;
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      if (wr_en) begin
        if (wr_off == REG_CTRL) enable <= s_axi_wdata[CTRL_ENABLE];
        for (int i = 0; i < C_NUM_PORTS; i++) begin
          if (wr_off == REG_DST_MAP + 32'(4 * i))
            dst_map[i] <= s_axi_wdata[7:0];
        end
      end
      // CLEAR takes priority over a same-cycle increment
      if (clr) fwd_cnt <= '0;
      else if (fwd_inc && fwd_cnt != '1) fwd_cnt <= fwd_cnt + 32'd1;
      if (clr) drop_cnt <= '0;
      else if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/packet_eval_output_mp.sv
// Packet evaluator: first-beat forward/drop/bypass decision,
// destination rewrite in tuser and a single registered output stage.
module packet_eval_output_mp
  import packet_eval_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'h7080_0000,
  parameter logic [31:0] C_HIGHADDR         = 32'h7080_ffff,
  parameter int          C_AXIS_DATA_WIDTH  = 256,
  parameter int          C_AXIS_TUSER_WIDTH = 128,
  parameter int          C_NUM_PORTS        = 8
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  pkt_state_e state_q;
  pkt_state_e state_d;
  logic [7:0]  cur_dst;
  logic        enable;
  logic [63:0] dst_flat;
  logic        s_hs;
  logic [7:0]  src;
  logic [3:0]  idx;
  logic [7:0]  dst_sel;
  logic        first_drop;
  logic        pass;
  logic        fwd_inc;
  logic        drop_inc;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_out;

  packet_eval_regs #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .C_BASEADDR         (C_BASEADDR),
    .C_HIGHADDR         (C_HIGHADDR),
    .C_NUM_PORTS        (C_NUM_PORTS)
  ) u_regs (
    .clk           (s_axi_aclk),
    .rst           (s_axi_areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .fwd_inc       (fwd_inc),
    .drop_inc      (drop_inc),
    .enable        (enable),
    .dst_flat      (dst_flat)
  );

  assign s_axis_tready = !s_axi_areset
                      && (state_q == ST_DROP
                          || !m_axis_tvalid || m_axis_tready);
  assign s_hs = s_axis_tvalid && s_axis_tready;

  always_comb begin
    src        = s_axis_tuser[TU_SRC_LSB +: 8];
    idx        = lowest_bit(src);
    dst_sel    = dst_flat[{idx[2:0], 3'b000} +: 8];
    first_drop = (src == 8'h00) || (idx >= 4'(C_NUM_PORTS))
              || (dst_sel == 8'h00);
  end

  always_comb begin
    state_d   = state_q;
    pass      = 1'b0;
    fwd_inc   = 1'b0;
    drop_inc  = 1'b0;
    tuser_out = s_axis_tuser;
    unique case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          if (!enable) begin
            pass = 1'b1;
            if (!s_axis_tlast) state_d = ST_BYPASS;
          end else if (first_drop) begin
            drop_inc = 1'b1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end else begin
            pass    = 1'b1;
            fwd_inc = s_axis_tlast;
            tuser_out[TU_DST_LSB +: 8] = dst_sel;
            if (!s_axis_tlast) state_d = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        if (s_hs) begin
          pass    = 1'b1;
          fwd_inc = s_axis_tlast;
          tuser_out[TU_DST_LSB +: 8] = cur_dst;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (s_hs && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_BYPASS: begin
        if (s_hs) begin
          pass = 1'b1;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q <= ST_IDLE;
      cur_dst <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && s_hs) cur_dst <= dst_sel;
    end
  end

  // Output holds its contents whenever no new beat is loaded
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (pass) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tstrb  <= s_axis_tstrb;
      m_axis_tuser  <= tuser_out;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_eval_output_mp.sv
// Directed bench for packet_eval_output_mp: vector table of
// packets plus hand-written stall, rewrite, counter and reset cases.
module tb_packet_eval_output_mp;

  localparam logic [31:0] BASE = 32'h7080_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [31:0]   araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [255:0]  s_tdata = '0;
  logic [31:0]   s_tstrb = '0;
  logic [127:0]  s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [255:0]  m_tdata;
  logic [31:0]   m_tstrb;
  logic [127:0]  m_tuser;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;

  always #5 clk = ~clk;

  packet_eval_output_mp dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  typedef struct {
    logic [255:0] data;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    logic [127:0] user;
    int           n;
    bit           fwd;
    logic [127:0] eu;
  } vec_t;

  beat_t out_q[$];
  beat_t exp_q[$];
  vec_t  vecs[6];
  int    tests = 0;
  int    fails = 0;
  int    rdy_low = 0;
  int    stall_viol = 0;
  int    stall_seen = 0;
  logic  prev_stall = 1'b0;
  logic [417:0] prev_snap = '0;
  logic [31:0] fwd_exp = 0;
  logic [31:0] drop_exp = 0;
  logic [31:0] rd;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready)
        out_q.push_back('{m_tdata, m_tuser, m_tlast});
      if (s_tvalid && !s_tready) rdy_low++;
      if (prev_stall) begin
        stall_seen++;
        if ({m_tvalid, m_tdata, m_tuser, m_tlast, m_tstrb} !== prev_snap)
          stall_viol++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_snap  = {m_tvalid, m_tdata, m_tuser, m_tlast, m_tstrb};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic axi_write(logic [31:0] off, logic [31:0] d);
    bit hs;
    int n = 0;
    awaddr = BASE + off; wdata = d; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    do begin
      @(negedge clk); hs = awready; tick(); n++;
    end while (!hs && n < 50);
    awvalid = 1'b0; wvalid = 1'b0;
    if (!hs) timeout("aw");
    n = 0;
    do begin
      @(negedge clk); hs = bvalid; tick(); n++;
    end while (!hs && n < 50);
    if (!hs) timeout("b");
  endtask

  task automatic axi_read(logic [31:0] off, output logic [31:0] d);
    bit hs;
    int n = 0;
    d = 'x;
    araddr = BASE + off; arvalid = 1'b1;
    do begin
      @(negedge clk); hs = arready; tick(); n++;
    end while (!hs && n < 50);
    arvalid = 1'b0;
    if (!hs) timeout("ar");
    n = 0;
    do begin
      @(negedge clk); hs = rvalid; d = rdata; tick(); n++;
    end while (!hs && n < 50);
    if (!hs) timeout("r");
  endtask

  task automatic check_cnt(string name);
    logic [31:0] v;
    axi_read(32'h04, v);
    check({name, " fwd_cnt"}, v, fwd_exp);
    axi_read(32'h08, v);
    check({name, " drop_cnt"}, v, drop_exp);
  endtask

  task automatic send_beat(logic [255:0] d, logic [127:0] u, logic l);
    bit hs;
    int n = 0;
    s_tdata = d; s_tuser = u; s_tlast = l;
    s_tstrb = '1; s_tvalid = 1'b1;
    do begin
      @(negedge clk); hs = s_tready; tick(); n++;
    end while (!hs && n < 100);
    if (!hs) timeout("s_axis");
  endtask

  task automatic send_pkt(int n, logic [127:0] u, logic [127:0] eu,
                          bit out, int tag);
    logic [255:0] d;
    for (int b = 0; b < n; b++) begin
      d = {224'd0, 16'(tag), 16'(b)};
      send_beat(d, u, b == n - 1);
      if (out) exp_q.push_back('{d, eu, b == n - 1});
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (5) tick();
  endtask

  task automatic compare_q(string name);
    int bad = 0;
    check({name, " beats"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      if (out_q[i].data !== exp_q[i].data
          || out_q[i].user !== exp_q[i].user
          || out_q[i].last !== exp_q[i].last) bad++;
    end
    check({name, " content"}, bad, 0);
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[0] = '{128'h0004_0060, 3, 1'b1, 128'h1004_0060};
    vecs[1] = '{128'h0002_0020, 2, 1'b0, 128'h0};
    vecs[2] = '{128'h0000_0010, 1, 1'b0, 128'h0};
    vecs[3] = '{128'h000C_0020, 1, 1'b1, 128'h100C_0020};
    vecs[4] = '{128'h1234_5678_9ABC_DEF0_0000_0000_FF01_0040, 2, 1'b1,
                128'h1234_5678_9ABC_DEF0_0000_0000_2101_0040};
    vecs[5] = '{128'h0080_0040, 2, 1'b0, 128'h0};

    repeat (3) tick();
    @(negedge clk);
    check("rst s_tready", s_tready, 0);
    check("rst m_axis", {m_tvalid, m_tdata, m_tuser, m_tlast, m_tstrb}, 0);
    check("rst axi", {awready, wready, bvalid, arready, rvalid,
                      rdata, bresp, rresp}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("s_tready after rst", s_tready, 1);
    tick();
    axi_read(32'h00, rd);
    check("rst ctrl", rd, 0);
    check_cnt("rst");

    axi_write(32'h18, 32'h10);
    axi_write(32'h10, 32'h21);
    axi_write(32'h00, 32'h1);
    axi_read(32'h18, rd);
    check("dst_map2 rb", rd, 32'h10);
    axi_read(32'h00, rd);
    check("ctrl rb", rd, 32'h1);
    axi_write(32'h0C, 32'hFFFF_FFFF);
    axi_read(32'h0C, rd);
    check("unmapped 0x0c", rd, 0);
    axi_read(32'h30, rd);
    check("unmapped 0x30", rd, 0);

    for (int i = 0; i < 6; i++) begin
      rdy_low = 0;
      send_pkt(vecs[i].n, vecs[i].user, vecs[i].eu, vecs[i].fwd, i);
      drain();
      compare_q($sformatf("vec%0d", i));
      check($sformatf("vec%0d s_tready low", i), rdy_low, 0);
      if (vecs[i].fwd) fwd_exp = sat_inc(fwd_exp);
      else drop_exp = sat_inc(drop_exp);
      check_cnt($sformatf("vec%0d", i));
    end

    axi_write(32'h00, 32'h0);
    send_pkt(2, 128'h00AB_0040, 128'h00AB_0040, 1'b1, 16);
    drain();
    compare_q("bypass");
    check_cnt("bypass");

    axi_write(32'h00, 32'h1);
    stall_seen = 0;
    stall_viol = 0;
    fork
      send_pkt(4, 128'h0004_0100, 128'h1004_0100, 1'b1, 17);
      begin
        for (int k = 0; k < 16; k++) begin
          m_tready = pat[k % 4];
          tick();
        end
        m_tready = 1'b1;
      end
    join
    drain();
    fwd_exp = sat_inc(fwd_exp);
    compare_q("stall");
    check("stall hold", stall_viol, 0);
    check("stall seen", stall_seen > 0, 1);

    send_beat({224'd0, 32'h0012_0000}, 128'h0001_0008, 1'b0);
    send_beat({224'd0, 32'h0012_0001}, 128'h0001_0008, 1'b0);
    s_tvalid = 1'b0;
    axi_write(32'h10, 32'h42);
    send_beat({224'd0, 32'h0012_0002}, 128'h0001_0008, 1'b1);
    s_tvalid = 1'b0;
    for (int b = 0; b < 3; b++)
      exp_q.push_back('{{224'd0, 16'h0012, 16'(b)}, 128'h2101_0008, b == 2});
    send_pkt(1, 128'h0001_0008, 128'h4201_0008, 1'b1, 19);
    drain();
    fwd_exp = sat_inc(sat_inc(fwd_exp));
    compare_q("dst rewrite");
    check_cnt("dst rewrite");

    force dut.u_regs.fwd_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.u_regs.fwd_cnt;
    fwd_exp = 32'hFFFF_FFFE;
    send_pkt(1, 128'h0004_0001, 128'h1004_0001, 1'b1, 20);
    drain();
    fwd_exp = sat_inc(fwd_exp);
    check_cnt("sat1");
    send_pkt(2, 128'h0004_0002, 128'h1004_0002, 1'b1, 21);
    drain();
    fwd_exp = sat_inc(fwd_exp);
    check_cnt("sat2");
    compare_q("sat");

    fork
      axi_write(32'h00, 32'h3);
      begin
        tick();
        send_pkt(1, 128'h0004_0003, 128'h1004_0003, 1'b1, 22);
      end
    join
    drain();
    fwd_exp = 0;
    drop_exp = 0;
    compare_q("clear");
    check_cnt("clear");
    axi_read(32'h00, rd);
    check("ctrl after clear", rd, 32'h1);

    send_pkt(1, 128'h0002_0001, 128'h0, 1'b0, 23);
    drain();
    drop_exp = sat_inc(drop_exp);
    check_cnt("pre rst");
    send_beat({224'd0, 32'h0018_0000}, 128'h0004_0004, 1'b0);
    s_tdata = {224'd0, 32'h0018_0001};
    rst = 1'b1;
    tick();
    check("rst mid m_tvalid", m_tvalid, 0);
    s_tvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst mid s_tready", s_tready, 1);
    tick();
    out_q.delete();
    exp_q.delete();
    fwd_exp = 0;
    drop_exp = 0;
    check_cnt("rst mid");
    axi_read(32'h18, rd);
    check("rst dst_map2", rd, 0);
    axi_write(32'h18, 32'h10);
    axi_write(32'h00, 32'h1);
    send_pkt(2, 128'h0002_0005, 128'h0, 1'b0, 24);
    drain();
    drop_exp = sat_inc(drop_exp);
    send_pkt(1, 128'h0004_0006, 128'h1004_0006, 1'b1, 25);
    drain();
    fwd_exp = sat_inc(fwd_exp);
    compare_q("post rst");
    check_cnt("post rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
